// File: rtl/mvt_mac_array.sv
// Multi-lane saturating multiply-accumulate engine for the MVT kernel.
// Each lane sums ROW_LEN filtered a*y terms through a two-stage pipeline.
module mvt_mac_array #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ACC_W   = 48,
  parameter int unsigned LANES   = 2,
  parameter int unsigned ROW_LEN = 16,
  parameter int unsigned Y_LIMIT = 100
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [LANES*DATA_W-1:0]  a_in_i,
  input  logic [LANES*DATA_W-1:0]  y_in_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [LANES*ACC_W-1:0]   x_out_o,
  output logic [LANES-1:0]         ovf_o
);

  localparam int unsigned PROD_W = 2 * DATA_W;
  localparam int unsigned SUM_W  = ((PROD_W > ACC_W) ? PROD_W : ACC_W) + 1;
  localparam int unsigned CNT_W  = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;

  typedef enum logic [1:0] {StAccum, StDrain, StHold} state_e;

  state_e                         state_q, state_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic                           s1_valid_q, s1_valid_d;
  logic                           live_q;
  logic [LANES-1:0][DATA_W-1:0]   a_lane, y_lane;
  logic [LANES-1:0][PROD_W-1:0]   term_q, term_d;
  logic [LANES-1:0][ACC_W-1:0]    acc_q, acc_d;
  logic [LANES-1:0]               ovf_q, ovf_d;
  logic [SUM_W-1:0]               sum;
  logic                           accept, last_beat, out_fire;

  assign a_lane = a_in_i;
  assign y_lane = y_in_i;

  // live_q keeps in_ready low until the first edge after reset release.
  assign in_ready_o  = live_q && (state_q == StAccum);
  assign accept      = in_valid_i && in_ready_o;
  assign last_beat   = (cnt_q == CNT_W'(ROW_LEN - 1));
  assign out_valid_o = (state_q == StHold);
  assign out_fire    = out_valid_o && out_ready_i;
  assign x_out_o     = acc_q;
  assign ovf_o       = ovf_q;

  // Stage 1: filtered full-width product per lane.
  always_comb begin
    term_d     = '0;
    s1_valid_d = accept && !clear_i;
    for (int unsigned l = 0; l < LANES; l++) begin
      if (y_lane[l] != '0 && y_lane[l] < DATA_W'(Y_LIMIT)) begin
        term_d[l] = PROD_W'(a_lane[l]) * PROD_W'(y_lane[l]);
      end
    end
  end

  // Stage 2: saturating accumulate; any carry above ACC_W bits means overflow.
  always_comb begin
    acc_d = acc_q;
    ovf_d = ovf_q;
    sum   = '0;
    if (s1_valid_q) begin
      for (int unsigned l = 0; l < LANES; l++) begin
        sum = SUM_W'(acc_q[l]) + SUM_W'(term_q[l]);
        if (sum[SUM_W-1:ACC_W] != '0) begin
          acc_d[l] = '1;
          ovf_d[l] = 1'b1;
        end else begin
          acc_d[l] = sum[ACC_W-1:0];
        end
      end
    end
    if (out_fire || clear_i) begin
      acc_d = '0;
      ovf_d = '0;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StAccum: begin
        if (accept) begin
          if (last_beat) begin
            cnt_d   = '0;
            state_d = StDrain;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StDrain: if (!s1_valid_q) state_d = StHold;
      StHold:  if (out_ready_i) state_d = StAccum;
      default: state_d = StAccum;
    endcase
    if (clear_i) begin
      state_d = StAccum;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StAccum;
      cnt_q      <= '0;
      s1_valid_q <= 1'b0;
      live_q     <= 1'b0;
      term_q     <= '0;
      acc_q      <= '0;
      ovf_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      s1_valid_q <= s1_valid_d;
      live_q     <= 1'b1;
      term_q     <= term_d;
      acc_q      <= acc_d;
      ovf_q      <= ovf_d;
    end
  end

endmodule

// File: tb/tb_mvt_mac_array.sv
// Directed bench for mvt_mac_array: one 32/48-bit instance and one 16/16-bit
// instance for saturation, both with LANES=2 and ROW_LEN=4.
module tb_mvt_mac_array;

  logic        clk = 1'b0;
  logic        rst_n;
  always #5 clk = ~clk;

  logic        clear, in_valid, in_ready, out_valid, out_ready;
  logic [63:0] a_in, y_in;
  logic [95:0] x_out;
  logic [1:0]  ovf;

  logic        c_clear, c_in_valid, c_in_ready, c_out_valid, c_out_ready;
  logic [31:0] c_a, c_y, c_x;
  logic [1:0]  c_ovf;

  int tests = 0;
  int fails = 0;

  mvt_mac_array #(
    .DATA_W(32), .ACC_W(48), .LANES(2), .ROW_LEN(4), .Y_LIMIT(100)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clear_i(clear), .in_valid_i(in_valid),
    .in_ready_o(in_ready), .a_in_i(a_in), .y_in_i(y_in), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .x_out_o(x_out), .ovf_o(ovf)
  );

  mvt_mac_array #(
    .DATA_W(16), .ACC_W(16), .LANES(2), .ROW_LEN(4), .Y_LIMIT(100)
  ) dut16 (
    .clk(clk), .rst_n(rst_n), .clear_i(c_clear), .in_valid_i(c_in_valid),
    .in_ready_o(c_in_ready), .a_in_i(c_a), .y_in_i(c_y), .out_valid_o(c_out_valid),
    .out_ready_i(c_out_ready), .x_out_o(c_x), .ovf_o(c_ovf)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic [31:0] a0, y0, a1, y1);
    a_in     = {a1, a0};
    y_in     = {y1, y0};
    in_valid = 1'b1;
  endtask

  task automatic beats(input int n, input logic [31:0] a0, y0, a1, y1);
    for (int i = 0; i < n; i++) begin
      drive(a0, y0, a1, y1);
      chk("beat_ready", in_ready, 1'b1);
      step();
    end
    in_valid = 1'b0;
  endtask

  // Called at the negedge right after the last accept; checks k+2 latency.
  task automatic expect_row(input string tag, input logic [47:0] x0, x1,
                            input logic [1:0] ov, input bit ack);
    chk({tag, "_drain0"}, out_valid, 1'b0);
    step();
    chk({tag, "_drain1"}, out_valid, 1'b0);
    chk({tag, "_drain_rdy"}, in_ready, 1'b0);
    step();
    chk({tag, "_valid"}, out_valid, 1'b1);
    chk({tag, "_x"}, x_out, {x1, x0});
    chk({tag, "_ovf"}, ovf, ov);
    chk({tag, "_hold_rdy"}, in_ready, 1'b0);
    if (ack) begin
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk({tag, "_post_rdy"}, in_ready, 1'b1);
      chk({tag, "_post_valid"}, out_valid, 1'b0);
      chk({tag, "_post_x"}, x_out, 96'd0);
    end
  endtask

  initial begin
    automatic logic [31:0] ys[4] = '{32'd0, 32'd99, 32'd100, 32'd1};
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a_in = '0; y_in = '0;
    c_clear = 1'b0; c_in_valid = 1'b0; c_out_ready = 1'b0; c_a = '0; c_y = '0;

    #3;
    chk("rst_ready", in_ready, 1'b0);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_x", x_out, 96'd0);
    chk("rst_ovf", ovf, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rel_ready0", in_ready, 1'b0);
    step();
    chk("rel_ready1", in_ready, 1'b1);

    // Lane 1 y out of range contributes nothing.
    beats(4, 3, 2, 7, 150);
    expect_row("t1", 48'd24, 48'd0, 2'b00, 1'b1);

    // Mixed y: only 99 and 1 pass the filter.
    for (int i = 0; i < 4; i++) begin
      drive(5, ys[i], 0, 0);
      chk("t2_ready", in_ready, 1'b1);
      step();
    end
    in_valid = 1'b0;
    expect_row("t2", 48'd500, 48'd0, 2'b00, 1'b1);

    // Backpressure in HOLD with in_valid pushing.
    beats(4, 2, 10, 4, 99);
    expect_row("t4a", 48'd80, 48'd1584, 2'b00, 1'b0);
    drive(9, 9, 9, 9);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t4_hold_valid", out_valid, 1'b1);
      chk("t4_hold_rdy", in_ready, 1'b0);
      chk("t4_hold_x", x_out, {48'd1584, 48'd80});
      chk("t4_hold_ovf", ovf, 2'b00);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("t4_ack_rdy", in_ready, 1'b1);
    chk("t4_ack_valid", out_valid, 1'b0);
    beats(4, 1, 3, 10, 1);
    expect_row("t4b", 48'd12, 48'd40, 2'b00, 1'b1);

    // clear with a beat in the same cycle drops the partial row.
    beats(2, 9, 9, 9, 9);
    drive(9, 9, 9, 9);
    clear = 1'b1;
    step();
    clear = 1'b0;
    in_valid = 1'b0;
    chk("t5_clr_valid", out_valid, 1'b0);
    chk("t5_clr_x", x_out, 96'd0);
    chk("t5_clr_rdy", in_ready, 1'b1);
    beats(4, 1, 1, 1, 1);
    expect_row("t5", 48'd4, 48'd4, 2'b00, 1'b1);

    // clear in HOLD drops the result even with out_ready high.
    beats(4, 1, 1, 1, 1);
    expect_row("t5b", 48'd4, 48'd4, 2'b00, 1'b0);
    clear = 1'b1;
    out_ready = 1'b1;
    step();
    clear = 1'b0;
    out_ready = 1'b0;
    chk("t5b_valid", out_valid, 1'b0);
    chk("t5b_x", x_out, 96'd0);
    chk("t5b_rdy", in_ready, 1'b1);

    // Asynchronous reset mid-DRAIN.
    beats(4, 5, 5, 5, 5);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", out_valid, 1'b0);
    chk("t6_rst_rdy", in_ready, 1'b0);
    chk("t6_rst_x", x_out, 96'd0);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("t6_rst_quiet", out_valid, 1'b0);
    end
    rst_n = 1'b1;
    chk("t6_rel_rdy0", in_ready, 1'b0);
    step();
    chk("t6_rel_rdy1", in_ready, 1'b1);
    beats(4, 2, 3, 2, 3);
    expect_row("t6", 48'd24, 48'd24, 2'b00, 1'b1);

    // Asynchronous reset in HOLD drops out_valid at once.
    beats(4, 1, 1, 1, 1);
    expect_row("t6b", 48'd4, 48'd4, 2'b00, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("t6b_valid", out_valid, 1'b0);
    chk("t6b_x", x_out, 96'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Saturation on the 16-bit instance.
    c_a = {16'd1, 16'd1000};
    c_y = {16'd1, 16'd50};
    c_in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("t3_ready", c_in_ready, 1'b1);
      step();
    end
    c_in_valid = 1'b0;
    step();
    step();
    chk("t3_valid", c_out_valid, 1'b1);
    chk("t3_x", c_x, {16'd4, 16'hFFFF});
    chk("t3_ovf", c_ovf, 2'b01);
    c_out_ready = 1'b1;
    step();
    c_out_ready = 1'b0;
    chk("t3_ovf_clr", c_ovf, 2'b00);
    c_a = {16'd1, 16'd1};
    c_y = {16'd1, 16'd1};
    c_in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("t3b_ready", c_in_ready, 1'b1);
      step();
    end
    c_in_valid = 1'b0;
    step();
    step();
    chk("t3b_valid", c_out_valid, 1'b1);
    chk("t3b_x", c_x, {16'd4, 16'd4});
    chk("t3b_ovf", c_ovf, 2'b00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mvt_mac_array.md
Name: mvt_mac_array

Overview:
- Parametrised multi-lane multiply-accumulate engine for the MVT kernel.
- Each lane computes one dot product, x[l] = sum over a row of A[l]*y[l]. Lanes run in lockstep, so x1 = A*y1 and x2 = A^T*y2 are computed concurrently.
- Consumes one term per lane per accepted beat. After ROW_LEN beats it presents the per-lane accumulated results on a valid/ready output handshake.

Parameters:
- DATA_W, 32: width of each A and y operand (unsigned).
- ACC_W, 48: accumulator and result width per lane.
- LANES, 2: number of parallel dot-product channels.
- ROW_LEN, 16: beats per row, i.e. terms per result. Must be >= 1.
- Y_LIMIT, 100: a term contributes only if 0 < y < Y_LIMIT.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous flush of the row in progress.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block accepts a beat this cycle.
- a_in  in  LANES*DATA_W  A operands; lane l occupies bits [l*DATA_W +: DATA_W].
- y_in  in  LANES*DATA_W  y operands; same lane packing as a_in.
- out_valid  out  1  results valid.
- out_ready  in  1  downstream accepts results.
- x_out  out  LANES*ACC_W  per-lane accumulated results; lane l occupies bits [l*ACC_W +: ACC_W].
- ovf  out  LANES  per-lane saturation flag for the presented row.

Behaviour:
Reset
- rst_n low: state = ACCUM; accumulators, term count and pipeline valids cleared; out_valid = 0; x_out = 0; ovf = 0.
- in_ready is forced to 0 while rst_n is low. It is 1 on the first clk edge after release.
- Asserting rst_n mid-row discards everything. No partial result is ever emitted.

Accept and term rules
- A beat is accepted when in_valid && in_ready.
- Term per lane: if y != 0 and y < Y_LIMIT, term = a*y as the full 2*DATA_W product; otherwise term = 0.
- A zero or skipped term still counts toward ROW_LEN.

Pipeline (2 stages)
- Stage 1 registers the term per lane.
- Stage 2 adds the term to the lane accumulator.
- Accumulation is unsigned and saturating. If the term exceeds 2^ACC_W-1, or the sum overflows, the accumulator becomes all-ones and the lane's sticky ovf bit sets.

State machine
- ACCUM: in_ready = 1. The term counter increments on each accepted beat. When the beat that makes count == ROW_LEN is accepted: go to DRAIN, count resets to 0.
- DRAIN: in_ready = 0. Wait until the last term has passed stage 2, then go to HOLD.
- HOLD: out_valid = 1; x_out and ovf show the final accumulator and flag values and stay stable while out_ready = 0.
  - On out_valid && out_ready: clear accumulators and ovf, go to ACCUM.
  - in_ready stays 0 in that handshake cycle and is 1 on the next cycle.

Latency
- Last beat accepted at edge k: out_valid = 1 after edge k+2.
- ROW_LEN = 1 behaves identically.

clear
- clear = 1 at an edge: flush pipeline valids, accumulators, ovf and count; go to ACCUM; out_valid = 0. Any result in HOLD is dropped.
- Takes priority over every other event in the same cycle, including a beat accept and an output handshake.

Throughput
- One beat per cycle in ACCUM.
- Per-row overhead is 2 DRAIN cycles plus the HOLD cycles.

Test Plan:
1. LANES=2, ROW_LEN=4: lane0 a=3 y=2 ×4 beats; lane1 a=7 y=150 ×4 beats -> out_valid 2 cycles after the 4th accept; x_out lane0 = 24, lane1 = 0; ovf = 00.
2. Mixed y on lane0 over 4 beats: y = 0, 99, 100, 1 with a = 5 each -> x = 500 (5*99 + 5*1); count still completes after 4 beats.
3. ACC_W=16, DATA_W=16: lane0 a=1000 y=50 ×4 -> x = 0xFFFF; ovf[0] = 1; lane1 (a=1 y=1) = 4 with ovf[1] = 0; the next row starts with ovf cleared.
4. Backpressure: out_ready held low 5 cycles in HOLD -> x_out and ovf stable, in_ready = 0, in_valid beats not accepted. Then out_ready = 1 -> next cycle in_ready = 1; the second row yields an independent correct sum.
5. clear asserted after 2 of 4 beats (same cycle as in_valid) -> that beat is not counted. The next 4 beats of a=1 y=1 give x = 4.
6. rst_n pulsed low asynchronously mid-DRAIN -> out_valid drops immediately, no result emitted. After release, a fresh row of a=2 y=3 ×4 gives x = 24.
